ax_branch_cycle_timer: RTL and testbench
========================================

# ax_branch_cycle_timer

Cycle-budget timer for approximate branches in the fetch unit; the direct upstream producer of the cycle counter, region begin cycle and threshold consumed by the cycle-based branch decider. Runs a free-running cycle counter and latches the begin cycle when fetch enters an approximate region. Holds the CSR-written threshold register and tracks region state, so the decider can force taken once the budget is exceeded.

## Interface
- `TIMER_WIDTH`, default 32: width of counter, begin cycle and threshold; equals `DataPath` width.
- `THRESHOLD_RESET`, default 1000: threshold value loaded at reset.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `regionBegin`  in  1  fetch detected an approximate-region entry, i.e. the first approximate-branch BTB hit in any lane.
- `regionEnd`  in  1  region exit: approximate branch resolved not-taken/exit.
- `flush`  in  1  pipeline flush; abandons the region.
- `thrWrEn`  in  1  threshold CSR write strobe.
- `thrWrData`  in  TIMER_WIDTH  threshold write value.
- `cycleCounter`  out  TIMER_WIDTH  free-running cycle count.
- `beginCycle`  out  TIMER_WIDTH  latched region begin cycle; equals `cycleCounter` while IDLE.
- `threshold`  out  TIMER_WIDTH  current threshold register.
- `regionActive`  out  1  state is ACTIVE or EXPIRED.
- `expired`  out  1  state is EXPIRED.

## Operation
- Counter: increments by 1 every cycle; wraps modulo 2^TIMER_WIDTH unless saturation is compiled in (see Configuration).
- States: IDLE, ACTIVE, EXPIRED.
- Elapsed time: `elapsed = cycleCounter - beginCycleReg`, computed modulo 2^TIMER_WIDTH. Expiry condition is `elapsed > threshold`, unsigned.
- IDLE:
  - `regionBegin & !flush` → ACTIVE, with `beginCycleReg <= cycleCounter` (value current in that cycle).
  - `regionEnd` alone is ignored.
- ACTIVE:
  - `flush` → IDLE. Flush has highest priority over every other input.
  - Else `regionBegin` (with or without `regionEnd`) → restart: re-latch `beginCycleReg`, stay ACTIVE.
  - Else `regionEnd` → IDLE.
  - Else expiry condition → EXPIRED.
- EXPIRED:
  - `flush` or `regionEnd` → IDLE.
  - `regionBegin` → restart into ACTIVE.
  - Sticky otherwise; a threshold rewrite never returns it to ACTIVE.
- `beginCycle` output = IDLE ? `cycleCounter` : `beginCycleReg`. The downstream test `cycleCounter > beginCycle + threshold` is therefore false in IDLE (barring counter wrap).
- Threshold: `thrWrEn` loads `thrWrData` at the clock edge, in any state. The new value is used for expiry evaluation from the next cycle.

## Timing
- Reset values:
  - `cycleCounter` = 0, `beginCycleReg` = 0, `threshold` = THRESHOLD_RESET.
  - State IDLE, so `regionActive` = 0 and `expired` = 0.
  - `beginCycle` = 0.
- `cycleCounter` = 0 in the first cycle after `rst` deasserts, then 1, 2, …
- `regionBegin` in cycle t (counter c):
  - `regionActive` = 1 and `beginCycle` = c in cycle t+1.
- Expiry latency: EXPIRED is visible one cycle after the first cycle in which `elapsed > threshold`. With threshold T this is the cycle where `cycleCounter` = c+T+2.
- All outputs are registered except the `beginCycle` mux and the `regionActive`/`expired` state decode. There are no combinational input→output paths.
- `rst` mid-region: immediate return to reset values, independent of the clock.

## Configuration
- `AX_CYCLE_COUNTER_SATURATE_EN`:
  - Defined: `cycleCounter` stops at all-ones and never wraps. Expiry evaluation then remains monotonic; a region begun near saturation expires only if T is smaller than the remaining headroom.
  - Undefined: the counter wraps to 0, and elapsed is computed modulo 2^TIMER_WIDTH.

## Structure
- Shared package FetchUnitTypes holds:
  - enum `AxCycleTimerState` {IDLE, ACTIVE, EXPIRED};
  - constants `AX_CYCLE_TIMER_WIDTH` and `AX_CYCLE_THRESHOLD_DEFAULT`.
- Sub-module `ax_cycle_counter`: free-running counter with the saturation option. The FSM, the begin/threshold registers and the output muxing stay in the top module.

## Test plan
- Reset then idle 10 cycles → `cycleCounter` = 9 in the 10th cycle, `beginCycle` == `cycleCounter`, `threshold` = 1000, `regionActive` = 0.
- Write threshold 5, `regionBegin` at counter 20 → `beginCycle` = 20, ACTIVE; `expired` rises when `cycleCounter` = 27 and stays high; `regionEnd` → IDLE next cycle.
- Threshold 0, `regionBegin` at counter 40 → `expired` = 1 at counter 42.
- ACTIVE with `regionBegin`, `regionEnd` and `flush` all asserted in one cycle → IDLE. With only `regionBegin` + `regionEnd` → stays ACTIVE with `beginCycle` re-latched.
- EXPIRED, then write threshold 0xFFFF_FFFF → remains EXPIRED. Assert `rst` mid-region → all outputs at reset values asynchronously.
- Preset counter near all-ones (force) with and without `AX_CYCLE_COUNTER_SATURATE_EN` → holds at 0xFFFF_FFFF vs wraps to 0.

Source files
------------

// File: rtl/ax_branch_cycle_timer_pkg.sv
// Shared fetch-unit types for the approximate-branch cycle timer.
// Optional feature macro used by this block: AX_CYCLE_COUNTER_SATURATE_EN.
package FetchUnitTypes;

    localparam int AX_CYCLE_TIMER_WIDTH       = 32;
    localparam int AX_CYCLE_THRESHOLD_DEFAULT = 1000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        EXPIRED = 2'd2
    } AxCycleTimerState;

    function automatic logic ax_state_in_region(input AxCycleTimerState st);
        return (st == ACTIVE) || (st == EXPIRED);
    endfunction

    function automatic logic ax_state_is_expired(input AxCycleTimerState st);
        return (st == EXPIRED);
    endfunction

endpackage

// File: rtl/ax_branch_cycle_timer_counter.sv
// Free-running cycle counter; wraps by default, holds at all-ones when
// AX_CYCLE_COUNTER_SATURATE_EN is defined.
module ax_cycle_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;

    // Next count value, with optional saturation at all-ones.
    always_comb begin
        count_next_s = count_r + WIDTH'(1);
`ifdef AX_CYCLE_COUNTER_SATURATE_EN
        if (count_r == {WIDTH{1'b1}}) begin
            count_next_s = count_r;
        end else begin
            count_next_s = count_r + WIDTH'(1);
        end
`endif
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/ax_branch_cycle_timer.sv
// Cycle-budget timer feeding the cycle-based approximate-branch decider.
// Counter saturation is selected with AX_CYCLE_COUNTER_SATURATE_EN.
import FetchUnitTypes::*;

module ax_branch_cycle_timer #(
    parameter int          TIMER_WIDTH     = AX_CYCLE_TIMER_WIDTH,
    parameter int unsigned THRESHOLD_RESET = AX_CYCLE_THRESHOLD_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   regionBegin,
    input  logic                   regionEnd,
    input  logic                   flush,
    input  logic                   thrWrEn,
    input  logic [TIMER_WIDTH-1:0] thrWrData,
    output logic [TIMER_WIDTH-1:0] cycleCounter,
    output logic [TIMER_WIDTH-1:0] beginCycle,
    output logic [TIMER_WIDTH-1:0] threshold,
    output logic                   regionActive,
    output logic                   expired
);

    AxCycleTimerState state_r;
    AxCycleTimerState state_next_s;

    logic [TIMER_WIDTH-1:0] counter_s;
    logic [TIMER_WIDTH-1:0] begin_cycle_r;
    logic [TIMER_WIDTH-1:0] threshold_r;
    logic [TIMER_WIDTH-1:0] elapsed_s;
    logic                   over_budget_s;
    logic                   latch_begin_s;

    ax_cycle_counter #(
        .WIDTH (TIMER_WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .count (counter_s)
    );

    // Elapsed time is modulo the counter width, so a wrap inside a region still measures correctly.
    always_comb begin
        elapsed_s     = counter_s - begin_cycle_r;
        over_budget_s = (elapsed_s > threshold_r);
    end

    // Region FSM next state; flush dominates, then restart, then exit, then expiry.
    always_comb begin
        state_next_s  = state_r;
        latch_begin_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (regionBegin && !flush) begin
                    state_next_s  = ACTIVE;
                    latch_begin_s = 1'b1;
                end else begin
                    state_next_s  = IDLE;
                end
            end
            ACTIVE: begin
                if (flush) begin
                    state_next_s  = IDLE;
                end else if (regionBegin) begin
                    state_next_s  = ACTIVE;
                    latch_begin_s = 1'b1;
                end else if (regionEnd) begin
                    state_next_s  = IDLE;
                end else if (over_budget_s) begin
                    state_next_s  = EXPIRED;
                end else begin
                    state_next_s  = ACTIVE;
                end
            end
            EXPIRED: begin
                // Sticky: only an exit, flush or fresh region entry leaves this state.
                if (flush || regionEnd) begin
                    state_next_s  = IDLE;
                end else if (regionBegin) begin
                    state_next_s  = ACTIVE;
                    latch_begin_s = 1'b1;
                end else begin
                    state_next_s  = EXPIRED;
                end
            end
            default: begin
                state_next_s  = IDLE;
                latch_begin_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Region begin cycle, captured from the counter value current in the entry cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            begin_cycle_r <= {TIMER_WIDTH{1'b0}};
        end else if (latch_begin_s) begin
            begin_cycle_r <= counter_s;
        end else begin
            begin_cycle_r <= begin_cycle_r;
        end
    end

    // Threshold CSR; writable in any state, takes effect for expiry from the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            threshold_r <= TIMER_WIDTH'(THRESHOLD_RESET);
        end else if (thrWrEn) begin
            threshold_r <= thrWrData;
        end else begin
            threshold_r <= threshold_r;
        end
    end

    // Output decode; in IDLE beginCycle tracks the counter so the decider never fires.
    always_comb begin
        cycleCounter = counter_s;
        threshold    = threshold_r;
        regionActive = ax_state_in_region(state_r);
        expired      = ax_state_is_expired(state_r);
        if (state_r == IDLE) begin
            beginCycle = counter_s;
        end else begin
            beginCycle = begin_cycle_r;
        end
    end

endmodule

// File: tb/tb_ax_branch_cycle_timer.sv
// Directed self-checking bench for ax_branch_cycle_timer.
module tb_ax_branch_cycle_timer;

    logic        clk;
    logic        rst;
    logic        regionBegin;
    logic        regionEnd;
    logic        flush;
    logic        thrWrEn;
    logic [31:0] thrWrData;
    logic [31:0] cycleCounter;
    logic [31:0] beginCycle;
    logic [31:0] threshold;
    logic        regionActive;
    logic        expired;

    int n_tests = 0;
    int n_fail  = 0;

    ax_branch_cycle_timer dut (
        .clk          (clk),
        .rst          (rst),
        .regionBegin  (regionBegin),
        .regionEnd    (regionEnd),
        .flush        (flush),
        .thrWrEn      (thrWrEn),
        .thrWrData    (thrWrData),
        .cycleCounter (cycleCounter),
        .beginCycle   (beginCycle),
        .threshold    (threshold),
        .regionActive (regionActive),
        .expired      (expired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        regionBegin = 1'b0;
        regionEnd   = 1'b0;
        flush       = 1'b0;
        thrWrEn     = 1'b0;
        thrWrData   = 32'd0;
        #7;
        check("rst_counter", cycleCounter, 32'd0);
        check("rst_begin", beginCycle, 32'd0);
        check("rst_threshold", threshold, 32'd1000);
        check("rst_active", {31'd0, regionActive}, 32'd0);
        check("rst_expired", {31'd0, expired}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("first_cycle_counter", cycleCounter, 32'd0);

        tick(9);
        check("idle10_counter", cycleCounter, 32'd9);
        check("idle10_begin", beginCycle, 32'd9);
        check("idle10_threshold", threshold, 32'd1000);
        check("idle10_active", {31'd0, regionActive}, 32'd0);

        thrWrEn = 1'b1; thrWrData = 32'd5;
        tick(1);
        thrWrEn = 1'b0;
        check("thr5_written", threshold, 32'd5);
        tick(10);
        check("at20_counter", cycleCounter, 32'd20);
        regionBegin = 1'b1;
        tick(1);
        regionBegin = 1'b0;
        check("t5_active", {31'd0, regionActive}, 32'd1);
        check("t5_begin", beginCycle, 32'd20);
        check("t5_not_exp_21", {31'd0, expired}, 32'd0);
        tick(5);
        check("t5_counter26", cycleCounter, 32'd26);
        check("t5_not_exp_26", {31'd0, expired}, 32'd0);
        tick(1);
        check("t5_exp_27", {31'd0, expired}, 32'd1);
        tick(3);
        check("t5_exp_sticky", {31'd0, expired}, 32'd1);
        check("t5_exp_active", {31'd0, regionActive}, 32'd1);
        regionEnd = 1'b1;
        tick(1);
        regionEnd = 1'b0;
        check("t5_end_active", {31'd0, regionActive}, 32'd0);
        check("t5_end_expired", {31'd0, expired}, 32'd0);
        check("t5_end_begin", beginCycle, 32'd31);

        thrWrEn = 1'b1; thrWrData = 32'd0;
        tick(1);
        thrWrEn = 1'b0;
        tick(8);
        check("at40_counter", cycleCounter, 32'd40);
        regionBegin = 1'b1;
        tick(1);
        regionBegin = 1'b0;
        check("t0_begin", beginCycle, 32'd40);
        check("t0_not_exp_41", {31'd0, expired}, 32'd0);
        tick(1);
        check("t0_exp_42", {31'd0, expired}, 32'd1);

        thrWrEn = 1'b1; thrWrData = 32'hFFFF_FFFF;
        tick(1);
        thrWrEn = 1'b0;
        check("thr_max_written", threshold, 32'hFFFF_FFFF);
        check("thr_max_still_exp", {31'd0, expired}, 32'd1);
        tick(1);
        check("thr_max_still_exp2", {31'd0, expired}, 32'd1);

        regionBegin = 1'b1;
        tick(1);
        regionBegin = 1'b0;
        check("exp_restart_expired", {31'd0, expired}, 32'd0);
        check("exp_restart_active", {31'd0, regionActive}, 32'd1);
        check("exp_restart_begin", beginCycle, 32'd44);

        regionBegin = 1'b1; regionEnd = 1'b1; flush = 1'b1;
        tick(1);
        regionBegin = 1'b0; regionEnd = 1'b0; flush = 1'b0;
        check("all3_active", {31'd0, regionActive}, 32'd0);
        check("all3_begin_idle", beginCycle, 32'd46);

        regionBegin = 1'b1;
        tick(1);
        regionBegin = 1'b0;
        check("re_enter_begin", beginCycle, 32'd46);
        tick(1);
        regionBegin = 1'b1; regionEnd = 1'b1;
        tick(1);
        regionBegin = 1'b0; regionEnd = 1'b0;
        check("beg_end_active", {31'd0, regionActive}, 32'd1);
        check("beg_end_relatch", beginCycle, 32'd48);

        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush_active", {31'd0, regionActive}, 32'd0);

        regionEnd = 1'b1;
        tick(1);
        regionEnd = 1'b0;
        check("idle_end_ignored", {31'd0, regionActive}, 32'd0);
        regionBegin = 1'b1; flush = 1'b1;
        tick(1);
        regionBegin = 1'b0; flush = 1'b0;
        check("idle_begin_flush", {31'd0, regionActive}, 32'd0);

        regionBegin = 1'b1;
        tick(1);
        regionBegin = 1'b0;
        check("pre_rst_active", {31'd0, regionActive}, 32'd1);
        check("pre_rst_begin", beginCycle, 32'd52);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_counter", cycleCounter, 32'd0);
        check("async_rst_begin", beginCycle, 32'd0);
        check("async_rst_threshold", threshold, 32'd1000);
        check("async_rst_active", {31'd0, regionActive}, 32'd0);
        check("async_rst_expired", {31'd0, expired}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        #1;
        force dut.u_counter.count_r = 32'hFFFF_FFFE;
        #1;
        release dut.u_counter.count_r;
        check("preset_counter", cycleCounter, 32'hFFFF_FFFE);
        tick(1);
        check("preset_all_ones", cycleCounter, 32'hFFFF_FFFF);
        check("preset_begin_idle", beginCycle, 32'hFFFF_FFFF);
        tick(1);
`ifdef AX_CYCLE_COUNTER_SATURATE_EN
        check("sat_hold", cycleCounter, 32'hFFFF_FFFF);
        tick(1);
        check("sat_hold2", cycleCounter, 32'hFFFF_FFFF);
`else
        check("wrap_zero", cycleCounter, 32'd0);
        tick(1);
        check("wrap_one", cycleCounter, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
